// File: rtl/btn_debounce_pkg.sv
// Shared types and constants for the button debouncer.
// Used by btn_debounce, including its DEBOUNCE_HOLD_EN long-press build.
package btn_debounce_pkg;

   // Debounce FSM states
   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   // Defaults: 20 ms debounce and 1 s long-press at 1 MHz
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 20000;
   localparam int unsigned HOLD_CYCLES_DEF     = 1000000;

   // Bits needed to hold values 0..max_val (at least one bit)
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/btn_debounce_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // Capture d, then re-register to let metastability resolve
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/btn_debounce.sv
// Button debouncer: synchronizes a bouncy button and produces a clean
// level plus one-cycle press/release pulses. Defining DEBOUNCE_HOLD_EN
// adds the held port and a long-press counter.
module btn_debounce
   import btn_debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic level,
   output logic rise,
   output logic fall
`ifdef DEBOUNCE_HOLD_EN
   ,
   output logic held
`endif
);

   localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   // Reject illegal parameterisations at elaboration
   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 32'd1048576 ||
       HOLD_CYCLES < 1 || HOLD_CYCLES > 32'd16777216) begin : g_bad_params
      $error("btn_debounce: DEBOUNCE_CYCLES or HOLD_CYCLES out of range");
   end

   logic          sync_in;
   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          level_next, rise_next, fall_next;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (in),
      .q     (sync_in)
   );

   // State, stability counter and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         level <= level_next;
         rise  <= rise_next;
         fall  <= fall_next;
      end
   end

   // Next state: a level must hold for DEBOUNCE_CYCLES samples to be accepted
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      rise_next  = 1'b0;
      fall_next  = 1'b0;
      case (state)
         IDLE: begin
            if (sync_in) begin
               state_next = PRESS_WAIT;
               cnt_next   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!sync_in) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt == CNT_MAX) begin
               state_next = PRESSED;
               cnt_next   = '0;
               rise_next  = 1'b1;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         PRESSED: begin
            if (!sync_in) begin
               state_next = RELEASE_WAIT;
               cnt_next   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (sync_in) begin
               state_next = PRESSED;
               cnt_next   = '0;
            end else if (cnt == CNT_MAX) begin
               state_next = IDLE;
               cnt_next   = '0;
               fall_next  = 1'b1;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
      level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
   end

`ifdef DEBOUNCE_HOLD_EN
   localparam int unsigned HW = cnt_width(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

   logic [HW-1:0] hold_cnt;
   logic          hold_done;

   // Long-press counter: runs while PRESSED, survives release bounce, clears in IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_cnt  <= '0;
         hold_done <= 1'b0;
         held      <= 1'b0;
      end else if (state == IDLE) begin
         hold_cnt  <= '0;
         hold_done <= 1'b0;
         held      <= 1'b0;
      end else begin
         held <= 1'b0;
         if (state == PRESSED) begin
            if (hold_cnt != HOLD_MAX) begin
               hold_cnt <= hold_cnt + HW'(1);
            end else if (!hold_done) begin
               held      <= 1'b1;
               hold_done <= 1'b1;
            end
         end
      end
   end
`endif

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20000, required stable clk cycles (20 ms at 1 MHz); legal range 2..2^20.
REQ-002 Parameter HOLD_CYCLES, default 1000000, continuous pressed cycles before a hold pulse; used only with DEBOUNCE_HOLD_EN; legal range 1..2^24.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 in  input  1  raw button level; asynchronous to clk and bouncy.
REQ-006 level  output  1  debounced button level.
REQ-007 rise  output  1  one-cycle pulse on each debounced press; this is the trigger for the downstream monostable.
REQ-008 fall  output  1  one-cycle pulse on each debounced release.
REQ-009 held  output  1  one-cycle long-press pulse; present only with DEBOUNCE_HOLD_EN.

Function
REQ-010 in SHALL pass through a 2-flop synchronizer; sync_in is the second flop's output, and only sync_in SHALL feed the FSM.
REQ-011 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, with a stability counter cnt sized to hold DEBOUNCE_CYCLES-1.
REQ-012 IDLE: sync_in=1 -> PRESS_WAIT with cnt=0; otherwise remain in IDLE.
REQ-013 PRESS_WAIT: sync_in=0 -> IDLE with cnt=0 (bounce rejected); sync_in=1 and cnt=DEBOUNCE_CYCLES-1 -> PRESSED with rise=1 for one cycle; otherwise cnt+1.
REQ-014 PRESSED: sync_in=0 -> RELEASE_WAIT with cnt=0; otherwise remain in PRESSED.
REQ-015 RELEASE_WAIT: sync_in=1 -> PRESSED with cnt=0 (no rise); sync_in=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE with fall=1 for one cycle; otherwise cnt+1.
REQ-016 level SHALL be 1 exactly in PRESSED and RELEASE_WAIT, and SHALL be registered and change in the same cycle as rise/fall.
REQ-017 Latency: with in stable high from before edge E0, rise SHALL be high after edge E0+DEBOUNCE_CYCLES+2 for exactly one cycle; release latency SHALL be symmetric.
REQ-018 Any input glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change on level, rise or fall.
REQ-019 rise and fall SHALL never assert in the same cycle, and SHALL strictly alternate starting with rise.
REQ-020 cnt SHALL never wrap; it saturates by the state transition at DEBOUNCE_CYCLES-1.

Reset
REQ-021 reset SHALL asynchronously clear both synchronizer flops, cnt and the hold counter, SHALL force the FSM to IDLE, and SHALL drive level=rise=fall=held=0.
REQ-022 reset asserted mid-debounce or while pressed SHALL emit no fall pulse.
REQ-023 After reset release with in held high, a full press qualification (REQ-017) SHALL occur and rise SHALL fire once.

Configuration
REQ-024 Macro DEBOUNCE_HOLD_EN defined: port held exists, and a hold counter counts cycles in PRESSED (RELEASE_WAIT does not clear it; entering IDLE clears it).
REQ-025 With DEBOUNCE_HOLD_EN: held pulses once when the hold counter reaches HOLD_CYCLES-1, then the counter saturates; at most one held pulse per press.
REQ-026 Macro undefined: no held port, no hold counter logic, and HOLD_CYCLES is ignored; all other behaviour is identical.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT), the default constants for DEBOUNCE_CYCLES and HOLD_CYCLES, and the counter-width function.
REQ-028 The synchronizer SHALL be a separate sub-module, sync_2ff (clk, reset, d, q), that is reusable for other async inputs.

Verification
REQ-029 DEBOUNCE_CYCLES=4; in 0->1 before edge 0 and held high -> rise=1 only after edge 6, level=1 from edge 6.
REQ-030 DEBOUNCE_CYCLES=4; in toggles high 2 cycles / low 1 cycle for 20 cycles, then stays low -> level, rise and fall remain 0 throughout.
REQ-031 DEBOUNCE_CYCLES=4, pressed; in low for 3 cycles then high -> no fall, level stays 1; then low for 10 cycles -> exactly one fall, level=0.
REQ-032 Pressed state with reset pulsed for 1 cycle -> all outputs 0 immediately and no fall; with in still high -> rise again after 6 edges following reset release.
REQ-033 DEBOUNCE_HOLD_EN with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8; press held 30 cycles -> one held pulse 8 cycles after rise; release and re-press -> a second held pulse.
REQ-034 Random in stream of 10k cycles with a scoreboard model -> rise/fall strictly alternate and each pulse is 1 cycle wide.
